// File: rtl/mem_bus_master.sv
// mem_bus_master: initiator side of the CPU data-memory bus.
// Accepts one load/store from the MEM stage, runs the ena/valid handshake
// toward the responder, and returns aligned, extended load data. Misaligned
// or illegal requests and responder timeouts finish with an err_o pulse.
module mem_bus_master #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        err_o,
    output logic        stall_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_data_o,
    output logic [3:0]  bus_sel_o,
    output logic        bus_ena_o,
    output logic        bus_w_r_o,
    input  logic [31:0] bus_data_i,
    input  logic        bus_valid_i,
    input  logic        bus_busy_i
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] baddr_q, baddr_d;
    logic [31:0] bdata_q, bdata_d;
    logic [3:0]  bsel_q, bsel_d;
    logic        bena_q, bena_d;
    logic        bwr_q, bwr_d;

    logic        misaligned;
    logic [3:0]  sel_c;
    logic [31:0] wrep_c;
    logic [31:0] shifted_c;
    logic [31:0] ext_c;

    // Alignment check on the live request; only meaningful in IDLE.
    always_comb begin
        misaligned = 1'b0;
        case (size_i)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr_i[0];
            2'b10:   misaligned = (addr_i[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Lane enables, store replication and load extraction from latched fields.
    always_comb begin
        sel_c  = 4'b1111;
        wrep_c = wdata_q;
        ext_c  = shifted_c;
        case (size_q)
            2'b00: begin
                sel_c  = 4'b0001 << addr_q[1:0];
                wrep_c = {4{wdata_q[7:0]}};
                ext_c  = {{24{sign_q & shifted_c[7]}}, shifted_c[7:0]};
            end
            2'b01: begin
                sel_c  = addr_q[1] ? 4'b1100 : 4'b0011;
                wrep_c = {2{wdata_q[15:0]}};
                ext_c  = {{16{sign_q & shifted_c[15]}}, shifted_c[15:0]};
            end
            default: begin
                sel_c  = 4'b1111;
                wrep_c = wdata_q;
                ext_c  = bus_data_i;
            end
        endcase
    end

    assign shifted_c = bus_data_i >> {addr_q[1:0], 3'b000};

    // Next-state and next-output logic for the handshake FSM.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        sign_d  = sign_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        baddr_d = baddr_q;
        bdata_d = bdata_q;
        bsel_d  = bsel_q;
        bena_d  = bena_q;
        bwr_d   = bwr_q;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    size_d  = size_i;
                    sign_d  = sign_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    if (misaligned) begin
                        state_d = S_ERR;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // Wait until the responder is idle and its valid from any
                // previous transfer has dropped.
                if (!bus_busy_i && !bus_valid_i) begin
                    state_d = S_WAIT;
                    bena_d  = 1'b1;
                    baddr_d = {2'b00, addr_q[31:2]};
                    bdata_d = wrep_c;
                    bsel_d  = sel_c;
                    bwr_d   = we_q;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (bus_valid_i) begin
                    state_d = S_DONE;
                    bena_d  = 1'b0;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    if (!we_q) rdata_d = ext_c;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERR;
                    bena_d  = 1'b0;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; async reset abandons any open transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            baddr_q <= '0;
            bdata_q <= '0;
            bsel_q  <= 4'b0000;
            bena_q  <= 1'b0;
            bwr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            baddr_q <= baddr_d;
            bdata_q <= bdata_d;
            bsel_q  <= bsel_d;
            bena_q  <= bena_d;
            bwr_q   <= bwr_d;
        end
    end

    assign stall_o    = ((state_q == S_IDLE) && req_i) || (state_q == S_REQ) || (state_q == S_WAIT);
    assign rdata_o    = rdata_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign bus_addr_o = baddr_q;
    assign bus_data_o = bdata_q;
    assign bus_sel_o  = bsel_q;
    assign bus_ena_o  = bena_q;
    assign bus_w_r_o  = bwr_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master: a table of single transfers followed by
// hand-written timeout, busy/valid-hold and mid-transfer reset sequences.
module tb_mem_bus_master;

    logic        clk;
    logic        rst;
    logic        req_i;
    logic        we_i;
    logic [1:0]  size_i;
    logic        sign_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        done_o;
    logic        err_o;
    logic        stall_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_data_o;
    logic [3:0]  bus_sel_o;
    logic        bus_ena_o;
    logic        bus_w_r_o;
    logic [31:0] bus_data_i;
    logic        bus_valid_i;
    logic        bus_busy_i;

    int checks = 0;
    int failures = 0;

    mem_bus_master #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .size_i(size_i),
        .sign_i(sign_i), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
        .done_o(done_o), .err_o(err_o), .stall_o(stall_o),
        .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o), .bus_sel_o(bus_sel_o),
        .bus_ena_o(bus_ena_o), .bus_w_r_o(bus_w_r_o), .bus_data_i(bus_data_i),
        .bus_valid_i(bus_valid_i), .bus_busy_i(bus_busy_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rsp;
        logic [3:0]  sel;
        logic [31:0] baddr;
        logic [31:0] bdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive_req(input vec_t v);
        req_i   = 1'b1;
        we_i    = v.we;
        size_i  = v.size;
        sign_i  = v.sign;
        addr_i  = v.addr;
        wdata_i = v.wdata;
    endtask

    // One transfer with a responder that answers on the first ena cycle.
    task automatic run_vec(input vec_t v, input int idx);
        int  n = 0;
        int  ena_n = 0;
        bit  done_seen = 0;
        @(negedge clk);
        drive_req(v);
        bus_data_i  = v.rsp;
        bus_valid_i = 1'b0;
        #1 chk($sformatf("v%0d stall_on_req", idx), 32'(stall_o), 32'd1);
        while (!done_seen && n < 20) begin
            @(negedge clk);
            n++;
            if (done_o) begin
                done_seen = 1;
                chk($sformatf("v%0d err", idx), 32'(err_o), 32'(v.err));
                chk($sformatf("v%0d rdata", idx), rdata_o, v.rdata);
                chk($sformatf("v%0d latency", idx), 32'(n), v.err ? 32'd1 : 32'd3);
                chk($sformatf("v%0d ena_cycles", idx), 32'(ena_n), v.err ? 32'd0 : 32'd1);
                chk($sformatf("v%0d stall_done", idx), 32'(stall_o), 32'd0);
                req_i       = 1'b0;
                bus_valid_i = 1'b0;
            end else begin
                chk($sformatf("v%0d stall_busy", idx), 32'(stall_o), 32'd1);
                if (bus_ena_o) begin
                    ena_n++;
                    if (ena_n == 1) begin
                        chk($sformatf("v%0d sel", idx), 32'(bus_sel_o), 32'(v.sel));
                        chk($sformatf("v%0d baddr", idx), bus_addr_o, v.baddr);
                        chk($sformatf("v%0d bdata", idx), bus_data_o, v.bdata);
                        chk($sformatf("v%0d w_r", idx), 32'(bus_w_r_o), 32'(v.we));
                    end
                    bus_valid_i = 1'b1;
                end
            end
        end
        if (!done_seen) begin
            chk($sformatf("v%0d done_timeout", idx), 32'd0, 32'd1);
            req_i = 1'b0;
            bus_valid_i = 1'b0;
        end
        @(negedge clk);
        chk($sformatf("v%0d done_pulse", idx), 32'({done_o, err_o, bus_ena_o}), 32'd0);
    endtask

    // Word load whose valid arrives on ena cycle `valid_at` (0 = never).
    task automatic run_timeout(input int valid_at, input logic [31:0] rsp,
                               input logic exp_err, input logic [31:0] exp_rdata,
                               input string tag);
        vec_t v;
        int   n = 0;
        int   ena_n = 0;
        bit   done_seen = 0;
        v = '{1'b0, 2'b10, 1'b0, 32'h8, 32'h0, rsp, 4'hF, 32'h2, 32'h0, 32'h0, 1'b0};
        @(negedge clk);
        drive_req(v);
        bus_data_i  = rsp;
        bus_valid_i = 1'b0;
        while (!done_seen && n < 20) begin
            @(negedge clk);
            n++;
            if (done_o) begin
                done_seen = 1;
                chk({tag, " err"}, 32'(err_o), 32'(exp_err));
                chk({tag, " ena_cycles"}, 32'(ena_n), 32'd4);
                chk({tag, " rdata"}, rdata_o, exp_rdata);
                req_i = 1'b0;
                bus_valid_i = 1'b0;
            end else if (bus_ena_o) begin
                ena_n++;
                if (ena_n == valid_at) bus_valid_i = 1'b1;
            end
        end
        if (!done_seen) begin
            chk({tag, " done_timeout"}, 32'd0, 32'd1);
            req_i = 1'b0;
            bus_valid_i = 1'b0;
        end
        @(negedge clk);
    endtask

    // Responder held busy (mode 0) or with stale valid high (mode 1) for 3 cycles.
    task automatic run_hold(input int mode, input logic [31:0] rsp, input string tag);
        vec_t v;
        int   n = 0;
        bit   done_seen = 0;
        v = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rsp, 4'hF, 32'h4, 32'h0, 32'h0, 1'b0};
        @(negedge clk);
        drive_req(v);
        bus_data_i  = rsp;
        bus_busy_i  = (mode == 0);
        bus_valid_i = (mode == 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("%s ena_low_%0d", tag, i), 32'({bus_ena_o, done_o}), 32'd0);
        end
        bus_busy_i  = 1'b0;
        bus_valid_i = 1'b0;
        @(negedge clk);
        chk({tag, " ena_rise"}, 32'(bus_ena_o), 32'd1);
        bus_valid_i = 1'b1;
        while (!done_seen && n < 10) begin
            @(negedge clk);
            n++;
            if (done_o) begin
                done_seen = 1;
                chk({tag, " err"}, 32'(err_o), 32'd0);
                chk({tag, " rdata"}, rdata_o, rsp);
                req_i = 1'b0;
                bus_valid_i = 1'b0;
            end
        end
        if (!done_seen) begin
            chk({tag, " done_timeout"}, 32'd0, 32'd1);
            req_i = 1'b0;
            bus_valid_i = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        vec_t v;
        bit   ena_seen;
        //        we    size   sign  addr          wdata         rsp           sel   baddr         bdata         rdata         err
        vt[0]  = '{1'b1, 2'b10, 1'b0, 32'h00000004, 32'hDEADBEEF, 32'h00000000, 4'hF, 32'h00000001, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vt[1]  = '{1'b0, 2'b00, 1'b1, 32'h00000003, 32'h00000000, 32'h80123456, 4'h8, 32'h00000000, 32'h00000000, 32'hFFFFFF80, 1'b0};
        vt[2]  = '{1'b0, 2'b00, 1'b0, 32'h00000003, 32'h00000000, 32'h80123456, 4'h8, 32'h00000000, 32'h00000000, 32'h00000080, 1'b0};
        vt[3]  = '{1'b1, 2'b01, 1'b0, 32'h00000002, 32'h0000ABCD, 32'h00000000, 4'hC, 32'h00000000, 32'hABCDABCD, 32'h00000080, 1'b0};
        vt[4]  = '{1'b0, 2'b01, 1'b1, 32'h00000000, 32'h00000000, 32'h12348001, 4'h3, 32'h00000000, 32'h00000000, 32'hFFFF8001, 1'b0};
        vt[5]  = '{1'b0, 2'b10, 1'b0, 32'h00000006, 32'h00000000, 32'h00000000, 4'h0, 32'h00000000, 32'h00000000, 32'hFFFF8001, 1'b1};
        vt[6]  = '{1'b0, 2'b11, 1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 4'h0, 32'h00000000, 32'h00000000, 32'hFFFF8001, 1'b1};
        vt[7]  = '{1'b1, 2'b01, 1'b0, 32'h00000001, 32'h00001111, 32'h00000000, 4'h0, 32'h00000000, 32'h00000000, 32'hFFFF8001, 1'b1};
        vt[8]  = '{1'b0, 2'b00, 1'b1, 32'h00000001, 32'h00000000, 32'h00007F00, 4'h2, 32'h00000000, 32'h00000000, 32'h0000007F, 1'b0};
        vt[9]  = '{1'b1, 2'b00, 1'b0, 32'h00000002, 32'h123456A5, 32'h00000000, 4'h4, 32'h00000000, 32'hA5A5A5A5, 32'h0000007F, 1'b0};
        vt[10] = '{1'b0, 2'b10, 1'b1, 32'h00000100, 32'h00000000, 32'hCAFEF00D, 4'hF, 32'h00000040, 32'h00000000, 32'hCAFEF00D, 1'b0};
        vt[11] = '{1'b0, 2'b01, 1'b1, 32'h00000002, 32'h00000000, 32'hF00D1234, 4'hC, 32'h00000000, 32'h00000000, 32'hFFFFF00D, 1'b0};
        vt[12] = '{1'b0, 2'b01, 1'b0, 32'h00000002, 32'h00000000, 32'hF00D1234, 4'hC, 32'h00000000, 32'h00000000, 32'h0000F00D, 1'b0};
        vt[13] = '{1'b1, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h01020304, 32'h00000000, 4'hF, 32'h3FFFFFFF, 32'h01020304, 32'h0000F00D, 1'b0};

        rst = 1'b0; req_i = 1'b0; we_i = 1'b0; size_i = 2'b00; sign_i = 1'b0;
        addr_i = '0; wdata_i = '0; bus_data_i = '0; bus_valid_i = 1'b0; bus_busy_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset rdata", rdata_o, 32'h0);
        chk("reset flags", 32'({done_o, err_o, stall_o, bus_ena_o, bus_w_r_o}), 32'd0);
        chk("reset bus_addr", bus_addr_o, 32'h0);
        chk("reset bus_data", bus_data_o, 32'h0);
        chk("reset bus_sel", 32'(bus_sel_o), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 14; i++) run_vec(vt[i], i);

        run_timeout(0, 32'h99999999, 1'b1, 32'h0000F00D, "timeout_novalid");
        run_timeout(4, 32'h11223344, 1'b0, 32'h11223344, "timeout_valid4");
        run_hold(0, 32'h55667788, "busy_hold");
        run_hold(1, 32'h0BADF00D, "valid_hold");

        // Reset pulsed while the transfer is waiting on the responder.
        v = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 4'hF, 32'h8, 32'h0, 32'h0, 1'b0};
        @(negedge clk);
        drive_req(v);
        ena_seen = 0;
        for (int i = 0; i < 5 && !ena_seen; i++) begin
            @(negedge clk);
            if (bus_ena_o) ena_seen = 1;
        end
        chk("rst_mid ena_reached", 32'(ena_seen), 32'd1);
        rst = 1'b0;
        req_i = 1'b0;
        #1;
        chk("rst_mid outputs", 32'({bus_ena_o, done_o, err_o, stall_o}), 32'd0);
        chk("rst_mid rdata", rdata_o, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        v = '{1'b0, 2'b00, 1'b0, 32'h00000000, 32'h0, 32'h000000AB, 4'h1, 32'h0, 32'h0, 32'h000000AB, 1'b0};
        run_vec(v, 99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
